// File: rtl/mips_pkg.sv
// mips_pkg: fetch FSM state encodings, instruction stride and pc alignment helper
package mips_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} fetch_state_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding {pc, instruction} entries; flush empties it in one cycle
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a small instruction buffer
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_t state, state_n;
  logic [31:0] fetch_pc;
  logic [63:0] head;
  logic [CW-1:0] count, occ_next;
  logic full, empty, push, pop, issue, reissue;
  assign pop = instr_valid && instr_ready;
  assign push = state == S_WAIT && imem_ack && !redirect;
  assign occ_next = count + CW'(push) - CW'(pop);
  assign issue = state == S_IDLE && !redirect && (!full || pop);
  assign reissue = push && occ_next < CW'(DEPTH);
  assign instr_valid = !empty;
  assign {instr_pc, instr} = head;
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .din({fetch_pc, imem_rdata}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // A redirect with the request still in flight must swallow the late response
  always_comb begin
    state_n = state;
    if (redirect) state_n = (state != S_IDLE && !imem_ack) ? S_DROP : S_IDLE;
    else if (state == S_IDLE) state_n = issue ? S_WAIT : S_IDLE;
    else if (imem_ack) state_n = reissue ? S_WAIT : S_IDLE;
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      imem_req <= state_n != S_IDLE;
      fetch_pc <= redirect ? word_align(redirect_pc) : push ? fetch_pc + INSTR_BYTES : fetch_pc;
      if (issue) imem_addr <= fetch_pc;
      else if (reissue) imem_addr <= fetch_pc + INSTR_BYTES;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and a randomized stream check for fetch_unit
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 0, reset_n = 0, imem_ack = 0, redirect = 0, instr_ready = 0;
  logic imem_req, instr_valid;
  logic [31:0] imem_rdata = 0, redirect_pc = 0, imem_addr, instr, instr_pc;
  int checks = 0, errors = 0, lat = 0, waited = 0;
  int nbuf, hs;
  bit stale, pend;
  logic [31:0] exp_pc, paddr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory answers after `lat` wait cycles, with a data word derived from the address
  task automatic mem_drive();
    imem_ack = imem_req && waited >= lat;
    imem_rdata = word(imem_addr);
  endtask

  task automatic tick();
    waited = (reset_n && imem_req && !imem_ack) ? waited + 1 : 0;
    @(negedge clk);
    mem_drive();
  endtask

  task automatic do_reset();
    reset_n = 0; redirect = 0; instr_ready = 0; lat = 0;
    tick(); tick();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    chk({name, " timeout"}, instr_valid, 1);
  endtask

  typedef struct {
    logic rdy; logic rd; logic [31:0] rpc;
    logic v; logic [31:0] pc; logic req; logic [31:0] addr;
  } vec_t;
  vec_t tbl [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h4};
    tbl[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 32'h8};
    tbl[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'hC};
    tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'hC};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'hC};
    tbl[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'hC};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'hC};
    tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'hC};
    tbl[9]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hC, 1'b1, 32'h10};
    tbl[10] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h14};
    tbl[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 32'h18};
    tbl[12] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, 32'h18};
    tbl[13] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8};
    tbl[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFC};
    tbl[15] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h4};

    do_reset();
    chk("reset valid", instr_valid, 0);
    chk("reset req", imem_req, 0);
    chk("reset addr", imem_addr, 32'h0);
    reset_n = 1;
    foreach (tbl[k]) begin
      instr_ready = tbl[k].rdy; redirect = tbl[k].rd; redirect_pc = tbl[k].rpc;
      tick();
      chk($sformatf("vec%0d valid", k), instr_valid, tbl[k].v);
      chk($sformatf("vec%0d req", k), imem_req, tbl[k].req);
      chk($sformatf("vec%0d addr", k), imem_addr, tbl[k].addr);
      if (tbl[k].v) begin
        chk($sformatf("vec%0d pc", k), instr_pc, tbl[k].pc);
        chk($sformatf("vec%0d instr", k), instr, word(tbl[k].pc));
      end
    end

    // Redirect while the memory is stalling: stale response must be dropped
    do_reset(); reset_n = 1; instr_ready = 1; lat = 3; mem_drive();
    tick(); tick();
    redirect = 1; redirect_pc = 32'h100;
    tick();
    redirect = 0;
    chk("drop req held", imem_req, 1);
    chk("drop addr held", imem_addr, 32'h0);
    chk("drop valid", instr_valid, 0);
    tick();
    chk("drop ack cycle req", imem_req, 1);
    tick();
    chk("drop idle req", imem_req, 0);
    chk("drop idle valid", instr_valid, 0);
    tick();
    chk("drop reissue addr", imem_addr, 32'h100);
    wait_valid("drop");
    chk("drop first pc", instr_pc, 32'h100);
    chk("drop first instr", instr, word(32'h100));

    // Redirect coinciding with the acknowledge
    do_reset(); reset_n = 1; instr_ready = 1; mem_drive();
    tick();
    chk("coinc ack present", imem_ack, 1);
    redirect = 1; redirect_pc = 32'h203;
    tick();
    redirect = 0;
    chk("coinc valid", instr_valid, 0);
    chk("coinc req", imem_req, 0);
    tick();
    chk("coinc next req", imem_req, 1);
    chk("coinc next addr", imem_addr, 32'h200);
    chk("coinc still empty", instr_valid, 0);
    tick();
    chk("coinc pc", instr_pc, 32'h200);
    chk("coinc instr valid", instr_valid, 1);

    // Reset pulse while a request is outstanding; a late ack must be ignored
    do_reset(); reset_n = 1; instr_ready = 1; mem_drive();
    repeat (4) tick();
    lat = 3; mem_drive();
    tick(); tick();
    chk("rstmid in wait", imem_req, 1);
    reset_n = 0;
    tick();
    chk("rstmid valid", instr_valid, 0);
    chk("rstmid req", imem_req, 0);
    chk("rstmid addr", imem_addr, 32'h0);
    chk("rstmid instr", instr, 32'h0);
    chk("rstmid pc", instr_pc, 32'h0);
    reset_n = 1; lat = 0; mem_drive();
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("late ack ignored", instr_valid, 0);
    chk("restart req", imem_req, 1);
    chk("restart addr", imem_addr, 32'h0);
    tick();
    chk("restart valid", instr_valid, 1);
    chk("restart pc", instr_pc, 32'h0);
    chk("restart instr", instr, word(32'h0));

    // Random stream: consumed pcs must follow program order, restarting at each redirect target
    do_reset(); reset_n = 1;
    exp_pc = 32'h0; nbuf = 0; stale = 0; hs = 0;
    for (int n = 0; n < 3000; n++) begin
      instr_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 15) == 0;
      redirect_pc = $urandom;
      lat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      mem_drive();
      if (redirect) begin
        stale = imem_req && !imem_ack;
        nbuf = 0;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (instr_valid && instr_ready) begin
          chk("rand pc", instr_pc, exp_pc);
          chk("rand instr", instr, word(exp_pc));
          exp_pc += 32'd4; nbuf--; hs++;
        end
        if (imem_req && imem_ack) begin
          if (!stale) nbuf++;
          stale = 0;
        end
      end
      pend = imem_req && !imem_ack;
      paddr = imem_addr;
      tick();
      chk("rand valid", instr_valid, nbuf > 0);
      chk("rand inflight", nbuf + int'(imem_req) <= DEPTH, 1);
      chk("rand addr align", imem_addr[1:0], 0);
      if (pend) begin
        chk("rand req held", imem_req, 1);
        chk("rand addr held", imem_addr, paddr);
      end
    end
    chk("rand throughput", hs > 300, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, the instruction buffer depth in entries (legal range 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  request valid to instruction memory.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_ack  input  1  memory accepted the request; imem_rdata is valid in this cycle.
REQ-008 SHALL have port imem_rdata  input  32  instruction word.
REQ-009 SHALL have port redirect  input  1  core taken branch/jump; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  32  new fetch address.
REQ-011 SHALL have port instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port instr  output  32  head instruction word.
REQ-013 SHALL have port instr_pc  output  32  address of the head instruction.
REQ-014 SHALL have port instr_ready  input  1  core consumes the head when it is high together with instr_valid.

Function
REQ-015 SHALL use a three-state FSM: IDLE (no outstanding request), WAIT (request outstanding, result kept), DROP (request outstanding, result discarded).
REQ-016 SHALL go from IDLE to WAIT, with imem_req and imem_addr registered, when the buffer has a free entry and redirect is low.
REQ-017 SHALL hold imem_req high and imem_addr stable from issue until the imem_ack cycle; at most one request is outstanding.
REQ-018 SHALL, on imem_ack in WAIT, push {fetch_pc, imem_rdata} into the buffer and advance fetch_pc by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL, on imem_ack in WAIT, issue the next request back-to-back (stay in WAIT with imem_addr + 4) when an entry remains free after this cycle's push and pop; otherwise go to IDLE.
REQ-020 SHALL, with a zero-wait memory and instr_ready held high, sustain one instruction per cycle.
REQ-021 SHALL present the buffer head on instr/instr_pc with one cycle of latency from the imem_ack push to instr_valid.
REQ-022 SHALL never request when buffer occupancy plus outstanding requests equals DEPTH; a push into a full buffer is therefore impossible.
REQ-023 SHALL, on redirect, empty the buffer, deassert instr_valid the next cycle, and load fetch_pc with {redirect_pc[31:2], 2'b00}.
REQ-024 SHALL, on redirect with a request outstanding and no imem_ack, go to DROP; the next imem_ack is discarded and the FSM goes to IDLE.
REQ-025 SHALL, on redirect coinciding with imem_ack, discard the returned word and go to IDLE.
REQ-026 SHALL give redirect priority over a same-cycle push and pop; a pop in the redirect cycle has no further effect.
REQ-027 SHALL support a simultaneous push and pop, leaving occupancy unchanged.

Reset
REQ-028 SHALL, while reset_n is low at a clock edge, set state to IDLE, fetch_pc to RESET_PC, buffer occupancy to 0, imem_req to 0, imem_addr to RESET_PC, instr_valid to 0, and instr and instr_pc to 0.
REQ-029 SHALL, when reset is asserted mid-request, abandon the outstanding request; an imem_ack arriving after reset release while in IDLE is ignored.
REQ-030 SHALL assert the first imem_req (addr RESET_PC) in the second cycle after reset_n rises.

Structure
REQ-031 SHALL take the FSM state encodings (IDLE/WAIT/DROP) and the instruction byte increment (4) from the shared package mips_pkg.
REQ-032 SHALL implement the buffer as one sub-module, fetch_fifo: a synchronous FIFO, DEPTH x 64 bits, with push, pop, flush, full, empty, and count.

Verification
REQ-033 SHALL test reset release with zero-wait memory and instr_ready=1: instr_pc sequence 0x0, 0x4, 0x8 on consecutive cycles.
REQ-034 SHALL test instr_ready=0 for 5 cycles: exactly DEPTH=2 words buffered, imem_req low, no lost or duplicated pc.
REQ-035 SHALL test a 3-cycle memory wait with redirect to 0x100 in wait cycle 2: the stale word is dropped, and the next instr_pc is 0x100.
REQ-036 SHALL test redirect to 0x203 coinciding with imem_ack: the word is discarded, and the next imem_addr is 0x200.
REQ-037 SHALL test redirect to 0xFFFF_FFF8: instr_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-038 SHALL test reset_n low for 1 cycle while in WAIT: instr_valid is 0, a late imem_ack is ignored, and fetch restarts at RESET_PC.
